// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences fetch, decode, execute, memory and writeback through one shared
// ALU and one handshaked unified memory port, counts retired instructions and
// raises a sticky trap on any opcode it cannot execute.
module multi_cycle_control_unit #(
   parameter int ENABLE_JUMP  = 1,
   parameter int ENABLE_UPPER = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam bit JUMP_ON  = (ENABLE_JUMP != 0);
   localparam bit UPPER_ON = (ENABLE_UPPER != 0);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      BRANCH = 3'd5,
      JUMP   = 3'd6,
      TRAP   = 3'd7
   } state_t;

   state_t           state_q;
   state_t           state_next;
   logic             illegal_q;
   logic [CNT_W-1:0] instret_q;
   logic             retire;

   logic is_r, is_i, is_load, is_store, is_branch;
   logic is_jal, is_jalr, is_lui, is_auipc;

   // Opcode classes; disabled groups simply never match and fall into TRAP
   always_comb begin
      is_r      = (opcode == OP_R);
      is_i      = (opcode == OP_I);
      is_load   = (opcode == OP_LOAD);
      is_store  = (opcode == OP_STORE);
      is_branch = (opcode == OP_BRANCH);
      is_jal    = JUMP_ON  && (opcode == OP_JAL);
      is_jalr   = JUMP_ON  && (opcode == OP_JALR);
      is_lui    = UPPER_ON && (opcode == OP_LUI);
      is_auipc  = UPPER_ON && (opcode == OP_AUIPC);
   end

   // Next-state selection and the retire strobe for the final step of each instruction
   always_comb begin
      state_next = state_q;
      retire     = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            if (is_r || is_i || is_load || is_store || is_jalr || is_lui || is_auipc)
               state_next = EXEC;
            else if (is_branch)
               state_next = BRANCH;
            else if (is_jal)
               state_next = JUMP;
            else
               state_next = TRAP;
         end
         EXEC: begin
            state_next = (is_load || is_store) ? MEM : WB;
         end
         MEM: begin
            if (mem_ready) begin
               if (is_store) begin
                  state_next = FETCH;
                  retire     = 1'b1;
               end else begin
                  state_next = WB;
               end
            end
         end
         WB: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         BRANCH: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         JUMP: begin
            state_next = WB;
         end
         TRAP: begin
            state_next = TRAP;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // State, retired-instruction counter and sticky trap flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         instret_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_next;
         if (retire) instret_q <= instret_q + CNT_ONE;
         if (state_next == TRAP) illegal_q <= 1'b1;
      end
   end

   // Datapath control decoded from the current state and the latched opcode
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      alu_src_a    = 2'd0;
      alu_src_b    = 2'd0;
      alu_op       = 2'b00;
      reg_write    = 1'b0;
      wb_sel       = 2'd0;
      unique case (state_q)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd2;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         DECODE: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
         end
         EXEC: begin
            if (is_r) begin
               alu_src_a = 2'd1;
               alu_op    = 2'b11;
            end else if (is_i) begin
               alu_src_a = 2'd1;
               alu_src_b = 2'd1;
               alu_op    = 2'b10;
            end else if (is_load || is_store) begin
               alu_src_a = 2'd1;
               alu_src_b = 2'd1;
            end else if (is_lui) begin
               alu_src_a = 2'd3;
               alu_src_b = 2'd1;
            end else if (is_auipc) begin
               alu_src_a = 2'd2;
               alu_src_b = 2'd1;
            end else if (is_jalr) begin
               alu_src_a = 2'd1;
               alu_src_b = 2'd1;
               pc_write  = 1'b1;
               pc_src    = 2'd2;
            end
         end
         MEM: begin
            mem_req      = 1'b1;
            mem_addr_src = 1'b1;
            mem_we       = is_store;
         end
         WB: begin
            reg_write = 1'b1;
            if (is_load)
               wb_sel = 2'd1;
            else if (is_jal || is_jalr)
               wb_sel = 2'd2;
         end
         BRANCH: begin
            alu_src_a = 2'd1;
            alu_op    = 2'b01;
            if (branch_taken) begin
               pc_write = 1'b1;
               pc_src   = 2'd1;
            end
         end
         JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
         end
         TRAP: begin
         end
         default: begin
         end
      endcase
   end

   assign state   = state_q;
   assign instret = instret_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: one full-featured instance and
// one with jumps disabled and a 4-bit counter, driven by the same stimulus.
module tb_multi_cycle_control_unit;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   typedef struct packed {
      logic [2:0]  st;
      logic        req;
      logic        we;
      logic        asrc;
      logic        irw;
      logic        pcw;
      logic [1:0]  pcs;
      logic [1:0]  a;
      logic [1:0]  b;
      logic [1:0]  op;
      logic        rw;
      logic [1:0]  wb;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        branch_taken;
   logic        mem_ready;

   logic        mem_req, mem_we, mem_addr_src, ir_write, pc_write, reg_write, illegal;
   logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
   logic [2:0]  state;
   logic [31:0] instret;

   logic        d2_mem_req, d2_mem_we, d2_mem_addr_src, d2_ir_write, d2_pc_write, d2_reg_write, d2_illegal;
   logic [1:0]  d2_pc_src, d2_alu_src_a, d2_alu_src_b, d2_alu_op, d2_wb_sel;
   logic [2:0]  d2_state;
   logic [3:0]  d2_instret;

   exp_t        obs;
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_cnt  = 0;

   multi_cycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_src(mem_addr_src), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
      .illegal(illegal), .state(state), .instret(instret)
   );

   multi_cycle_control_unit #(.ENABLE_JUMP(0), .ENABLE_UPPER(1), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(d2_mem_req), .mem_we(d2_mem_we),
      .mem_addr_src(d2_mem_addr_src), .ir_write(d2_ir_write), .pc_write(d2_pc_write),
      .pc_src(d2_pc_src), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
      .alu_op(d2_alu_op), .reg_write(d2_reg_write), .wb_sel(d2_wb_sel),
      .illegal(d2_illegal), .state(d2_state), .instret(d2_instret)
   );

   always #5 clk = ~clk;

   assign obs = {state, mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal, instret};

   function automatic exp_t mk(input int st, input int req, input int we, input int asrc,
                               input int irw, input int pcw, input int pcs, input int a,
                               input int b, input int op, input int rw, input int wb,
                               input int ill, input int cnt);
      exp_t e;
      e.st   = 3'(st);
      e.req  = 1'(req);
      e.we   = 1'(we);
      e.asrc = 1'(asrc);
      e.irw  = 1'(irw);
      e.pcw  = 1'(pcw);
      e.pcs  = 2'(pcs);
      e.a    = 2'(a);
      e.b    = 2'(b);
      e.op   = 2'(op);
      e.rw   = 1'(rw);
      e.wb   = 2'(wb);
      e.ill  = 1'(ill);
      e.cnt  = 32'(cnt);
      return e;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] opc, input logic ready, input logic taken);
      opcode       = opc;
      mem_ready    = ready;
      branch_taken = taken;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      checkVal(tag, 64'(obs), 64'(e));
   endtask

   // one clock: drive, record the expectation, compare mid-cycle, step to the next cycle
   task automatic cyc(input string tag, input logic [6:0] opc, input logic ready,
                      input logic taken, input exp_t e);
      applyStimulus(opc, ready, taken);
      sb.push_back(e);
      checkOutput(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic fetchPhase(input logic [6:0] opc, input int waits);
      for (int i = 0; i < waits; i++)
         cyc("fetch_wait", opc, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,2,0,0,0,0,exp_cnt));
      cyc("fetch", opc, 1'b1, 1'b0, mk(0,1,0,0,1,1,0,0,2,0,0,0,0,exp_cnt));
      cyc("decode", opc, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,2,1,0,0,0,0,exp_cnt));
   endtask

   task automatic runAlu(input logic [6:0] opc, input int a, input int b, input int op, input int waits);
      fetchPhase(opc, waits);
      cyc("exec_alu", opc, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,a,b,op,0,0,0,exp_cnt));
      cyc("wb_alu", opc, 1'b0, 1'b0, mk(4,0,0,0,0,0,0,0,0,0,1,0,0,exp_cnt));
      exp_cnt++;
   endtask

   task automatic runMem(input logic [6:0] opc, input int is_store, input int waits);
      fetchPhase(opc, 0);
      cyc("exec_mem", opc, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,1,1,0,0,0,0,exp_cnt));
      for (int i = 0; i < waits; i++)
         cyc("mem_wait", opc, 1'b0, 1'b0, mk(3,1,is_store,1,0,0,0,0,0,0,0,0,0,exp_cnt));
      cyc("mem_done", opc, 1'b1, 1'b0, mk(3,1,is_store,1,0,0,0,0,0,0,0,0,0,exp_cnt));
      if (is_store == 0)
         cyc("wb_load", opc, 1'b0, 1'b0, mk(4,0,0,0,0,0,0,0,0,0,1,1,0,exp_cnt));
      exp_cnt++;
   endtask

   task automatic runBranch(input int taken);
      fetchPhase(OP_BRANCH, 0);
      cyc("branch", OP_BRANCH, 1'b0, 1'(taken), mk(5,0,0,0,0,taken,taken,1,0,1,0,0,0,exp_cnt));
      exp_cnt++;
   endtask

   task automatic runJal();
      fetchPhase(OP_JAL, 0);
      cyc("jump", OP_JAL, 1'b0, 1'b0, mk(6,0,0,0,0,1,1,0,0,0,0,0,0,exp_cnt));
      cyc("wb_jal", OP_JAL, 1'b0, 1'b0, mk(4,0,0,0,0,0,0,0,0,0,1,2,0,exp_cnt));
      exp_cnt++;
   endtask

   task automatic runJalr();
      fetchPhase(OP_JALR, 0);
      cyc("exec_jalr", OP_JALR, 1'b0, 1'b0, mk(2,0,0,0,0,1,2,1,1,0,0,0,0,exp_cnt));
      cyc("wb_jalr", OP_JALR, 1'b0, 1'b0, mk(4,0,0,0,0,0,0,0,0,0,1,2,0,exp_cnt));
      exp_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(OP_R, 1'b0, 1'b0);
      #7;
      checkVal("reset_outputs", 64'(obs), 64'(mk(0,1,0,0,0,0,0,0,2,0,0,0,0,0)));
      checkVal("reset_d2_state", 64'(d2_state), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      runAlu(OP_R, 1, 0, 3, 0);
      checkVal("instret_after_r", 64'(instret), 64'd1);
      runMem(OP_LOAD, 0, 2);
      runMem(OP_STORE, 1, 0);
      runBranch(1);
      runBranch(0);
      checkVal("instret_after_branches", 64'(instret), 64'd5);
      runAlu(OP_I, 1, 1, 2, 1);
      runAlu(OP_LUI, 3, 1, 0, 0);
      runAlu(OP_AUIPC, 2, 1, 0, 0);

      runJal();
      checkVal("d2_jal_trap_state", 64'(d2_state), 64'd7);
      checkVal("d2_jal_trap_flag", 64'(d2_illegal), 64'd1);
      checkVal("d2_instret_frozen", 64'(d2_instret), 64'd8);
      runJalr();
      checkVal("d2_trap_held", 64'(d2_state), 64'd7);
      checkVal("d2_trap_req_low", 64'(d2_mem_req), 64'd0);

      fetchPhase(OP_BAD, 0);
      for (int i = 0; i < 3; i++)
         cyc("trap", OP_BAD, 1'b1, 1'b0, mk(7,0,0,0,0,0,0,0,0,0,0,0,1,exp_cnt));

      applyStimulus(OP_R, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkVal("trap_reset_outputs", 64'(obs), 64'(mk(0,1,0,0,0,0,0,0,2,0,0,0,0,0)));
      checkVal("trap_reset_d2_state", 64'(d2_state), 64'd0);
      checkVal("trap_reset_d2_flag", 64'(d2_illegal), 64'd0);
      checkVal("trap_reset_d2_cnt", 64'(d2_instret), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = 0;

      for (int i = 0; i < 16; i++) begin
         runAlu(OP_R, 1, 0, 3, 0);
         if (i == 14) checkVal("d2_cnt_at_15", 64'(d2_instret), 64'd15);
      end
      checkVal("d2_cnt_wrapped", 64'(d2_instret), 64'd0);
      checkVal("cnt_16", 64'(instret), 64'd16);

      fetchPhase(OP_STORE, 0);
      cyc("exec_store", OP_STORE, 1'b0, 1'b0, mk(2,0,0,0,0,0,0,1,1,0,0,0,0,exp_cnt));
      cyc("mem_stall", OP_STORE, 1'b0, 1'b0, mk(3,1,1,1,0,0,0,0,0,0,0,0,0,exp_cnt));
      #2 rst_n = 1'b0;
      #1;
      checkVal("mid_mem_reset", 64'(obs), 64'(mk(0,1,0,0,0,0,0,0,2,0,0,0,0,0)));
      @(posedge clk);
      #1;
      checkVal("reset_hold_state", 64'(state), 64'd0);
      checkVal("reset_hold_cnt", 64'(instret), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = 0;
      runAlu(OP_R, 1, 0, 3, 0);
      checkVal("cnt_after_abandon", 64'(instret), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
